instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Encoder counterpart of the core's opcode/control decoder.
- Accepts field-level instruction requests (kind, registers, funct, immediate) over a valid/ready handshake and packs each into a 32-bit RV32I word for lw, sw, R-type or beq.
- Emits each word on a registered valid/ready output stream, tagged with an auto-incrementing instruction-memory word address.
- Used by the program loader and debug injector to fill instruction memory for the core; malformed requests are consumed, dropped and flagged.

Parameters:
- ADDR_W, 10, width of the emitted word address; the address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: drops the held word, zeroes the address and count, clears the error.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_kind  in  3  0=LW, 1=SW, 2=R, 3=BEQ; 4..7 illegal.
- req_rd  in  5  destination register (LW, R).
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2 (SW, R, BEQ).
- req_funct3  in  3  funct3 field, passed through unchanged.
- req_funct7b5  in  1  R only; funct7 = {1'b0, b5, 5'b0}.
- req_imm  in  13  signed immediate (byte offset).
- out_valid  out  1  encoded word held.
- out_ready  in  1  consumer accepts the word.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_word.
- word_count  out  ADDR_W+1  number of words handed off since reset/clear; saturates at all-ones.
- err  out  1  sticky: a request was rejected.
- err_code  out  2  first error only: 1=illegal kind, 2=imm out of range, 3=BEQ odd offset.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_word=0, out_addr=0, word_count=0, err=0, err_code=0. Outputs are valid from the first edge after deassertion.
- req_ready = !out_valid || out_ready. This is combinational from out_valid and out_ready only, never from req_valid.
- Latency: a legal request accepted at edge N gives out_valid=1 with its word after edge N. Full throughput of one word per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_word and out_addr hold stable and req_ready=0.
- out_addr advances by 1 on each output handshake (out_valid && out_ready) and wraps from 2^ADDR_W-1 to 0. word_count increments on the same handshake and saturates rather than wrapping.
- Encodings (opcode in bits [6:0]):
  - LW: {imm[11:0], rs1, funct3, rd, 7'b0000011}
  - SW: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}
  - BEQ: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}
- Legality checks:
  - LW/SW: imm must lie in -2048..2047; otherwise code 2.
  - BEQ: imm[0] must be 0; otherwise code 3. The full 13-bit range is legal.
  - Kind 4..7: code 1.
- An illegal request is still accepted under the normal req_ready rule. It produces no word, and out_addr and word_count are unchanged. The output register behaves as if no request arrived: it completes any pending handoff and becomes empty.
- err is set on the edge after the rejected request. err_code latches only when err was 0; both hold until clear or rst.
- clear has priority over everything in the same cycle:
  - out_valid drops, and no handoff counts even if out_ready=1.
  - Any request offered that cycle is not accepted; req_ready is forced to 0 while clear=1.
  - out_addr, word_count, err and err_code return to 0.
- A reset mid-stall discards the held word.

Decomposition:
- Shared package instr_pkg holds:
  - the opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, also used by the decoder;
  - a kind enum (KIND_LW, KIND_SW, KIND_R, KIND_BEQ);
  - an err-code enum.
- Sub-module instr_pack: purely combinational, taking kind/fields/imm to {word, legal, code}.
- The top level holds the output register, handshake, address/count counters and error latch.

Test Plan:
- LW rd=5 rs1=2 funct3=2 imm=8, out_ready=1 -> out_word=0x00812283, out_addr=0, then word_count=1.
- SW rs2=6 rs1=3 funct3=2 imm=12, followed back-to-back by R add rd=1 rs1=2 rs2=3 funct7b5=0, then R with funct7b5=1 -> 0x0061A623 @0, 0x003100B3 @1, 0x403100B3 @2 on consecutive cycles.
- BEQ rs1=1 rs2=2 funct3=0 imm=-8 with out_ready held 0 for 3 cycles -> out_word=0xFE208CE3 stable, req_ready=0 throughout; handoff when ready rises.
- BEQ imm=7, then LW imm=3000, then kind=5 -> no words, addr/count unchanged, err=1, err_code=3 (first error retained).
- ADDR_W=2: 5 legal requests -> out_addr sequence 0,1,2,3,0; word_count=5.
- Assert clear while out_valid=1 and out_ready=1, with req_valid=1 -> no handoff counted, request not accepted, out_valid=0, out_addr=0, word_count=0, err=0. Separately, assert rst mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared opcode constants and request/error enums for the instruction
// encoder and its decoder counterpart.
package instr_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      KIND_LW  = 3'd0,
      KIND_SW  = 3'd1,
      KIND_R   = 3'd2,
      KIND_BEQ = 3'd3
   } kind_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_KIND  = 2'd1,
      ERR_IMM   = 2'd2,
      ERR_ALIGN = 2'd3
   } err_e;

   // A 13-bit signed value fits in 12 bits when its top two bits agree.
   function automatic logic imm12_fits(input logic [12:0] imm);
      return imm[12] == imm[11];
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: field-level request -> RV32I word plus legality
// verdict and the error code that applies when it is rejected.
module instr_pack
   import instr_pkg::*;
(
   input  logic [2:0]  i_kind,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic        i_funct7b5,
   input  logic [12:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_legal,
   output logic [1:0]  o_code
);

   always_comb begin
      o_word  = '0;
      o_legal = 1'b0;
      o_code  = ERR_KIND;
      case (i_kind)
         KIND_LW: begin
            o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
            o_legal = imm12_fits(i_imm);
            o_code  = o_legal ? ERR_NONE : ERR_IMM;
         end
         KIND_SW: begin
            o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
            o_legal = imm12_fits(i_imm);
            o_code  = o_legal ? ERR_NONE : ERR_IMM;
         end
         KIND_R: begin
            o_word  = {1'b0, i_funct7b5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OP_RTYPE};
            o_legal = 1'b1;
            o_code  = ERR_NONE;
         end
         KIND_BEQ: begin
            // Branch offsets are in halfwords, so bit 0 has no slot in the word.
            o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], OP_BRANCH};
            o_legal = ~i_imm[0];
            o_code  = o_legal ? ERR_NONE : ERR_ALIGN;
         end
         default: begin
            o_legal = 1'b0;
            o_code  = ERR_KIND;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field requests, emits packed words on a
// registered valid/ready stream with a wrapping word address.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_kind,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs1,
   input  logic [4:0]        req_rs2,
   input  logic [2:0]        req_funct3,
   input  logic              req_funct7b5,
   input  logic [12:0]       req_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_word,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ADDR_W:0]   word_count,
   output logic              err,
   output logic [1:0]        err_code
);

   logic              r_valid;
   logic [31:0]       r_word;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_err;
   logic [1:0]        r_code;

   logic [31:0] w_word;
   logic        w_legal;
   logic [1:0]  w_code;
   logic        w_slot;
   logic        w_accept;
   logic        w_handoff;

   instr_pack u_pack (
      .i_kind     (req_kind),
      .i_rd       (req_rd),
      .i_rs1      (req_rs1),
      .i_rs2      (req_rs2),
      .i_funct3   (req_funct3),
      .i_funct7b5 (req_funct7b5),
      .i_imm      (req_imm),
      .o_word     (w_word),
      .o_legal    (w_legal),
      .o_code     (w_code)
   );

   // The output slot frees up when empty or being drained this cycle.
   assign w_slot    = !r_valid || out_ready;
   assign req_ready = w_slot && !clear;
   assign w_accept  = req_valid && req_ready;
   assign w_handoff = r_valid && out_ready && !clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_word  <= '0;
         r_addr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
         r_code  <= ERR_NONE;
      end else if (clear) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
         r_code  <= ERR_NONE;
      end else begin
         if (w_handoff) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_count != '1)
               r_count <= r_count + (ADDR_W+1)'(1);
         end
         if (w_slot) begin
            r_valid <= w_accept && w_legal;
            if (w_accept && w_legal)
               r_word <= w_word;
         end
         if (w_accept && !w_legal) begin
            r_err <= 1'b1;
            if (!r_err)
               r_code <= w_code;
         end
      end
   end

   assign out_valid  = r_valid;
   assign out_word   = r_word;
   assign out_addr   = r_addr;
   assign word_count = r_count;
   assign err        = r_err;
   assign err_code   = r_code;

endmodule
